// File: rtl/shadow_reg_pkg.sv
// Shared types for the shadowed configuration register: sequencer phase and
// an error bundle for aggregation at the register-file top.
package shadow_reg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STAGED = 1'b1
  } shadow_phase_e;

  typedef struct packed {
    logic update;
    logic storage;
  } shadow_err_t;

endpackage : shadow_reg_pkg

// File: rtl/shadow_reg_ctrl_if.sv
// Register-bus side of a shadowed register: write/read strobes in,
// committed value, readback, phase and error flags out.
interface shadow_reg_ctrl_if #(
  parameter int DW = 5
);
  logic          we_i;
  logic [DW-1:0] wd_i;
  logic          re_i;
  logic [DW-1:0] q_o;
  logic [DW-1:0] qs_o;
  logic          phase_o;
  logic          err_update_o;
  logic          err_storage_o;

  modport master (
    output we_i, wd_i, re_i,
    input  q_o, qs_o, phase_o, err_update_o, err_storage_o
  );

  modport slave (
    input  we_i, wd_i, re_i,
    output q_o, qs_o, phase_o, err_update_o, err_storage_o
  );
endinterface : shadow_reg_ctrl_if

// File: rtl/shadow_reg_storage.sv
// Committed value plus its bitwise-inverted shadow, loaded together on a
// single commit enable; mismatch_o flags any disagreement between the two.
module shadow_reg_storage #(
  parameter int            DW     = 5,
  parameter logic [DW-1:0] RESVAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          commit_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] committed_o,
  output logic          mismatch_o
);

  logic [DW-1:0] committed_q;
  logic [DW-1:0] shadow_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      committed_q <= RESVAL;
      shadow_q    <= ~RESVAL;
    end else if (commit_i) begin
      committed_q <= wd_i;
      shadow_q    <= ~wd_i;
    end
  end

  assign committed_o = committed_q;
  assign mismatch_o  = (committed_q != ~shadow_q);

endmodule : shadow_reg_storage

// File: rtl/shadow_reg_ctrl.sv
// Double-write sequencer for a shadowed configuration register: a value
// commits only when written twice in a row; update and storage errors flagged.
module shadow_reg_ctrl
  import shadow_reg_pkg::*;
#(
  parameter int            DW     = 5,
  parameter logic [DW-1:0] RESVAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  shadow_reg_ctrl_if.slave bus
);

  shadow_phase_e state_q, state_d;
  logic [DW-1:0] staged_q, staged_d;
  shadow_err_t   err_q, err_d;
  logic          commit;
  logic          mismatch;
  logic [DW-1:0] committed;

  shadow_reg_storage #(
    .DW     (DW),
    .RESVAL (RESVAL)
  ) u_storage (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .commit_i    (commit),
    .wd_i        (bus.wd_i),
    .committed_o (committed),
    .mismatch_o  (mismatch)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    staged_d       = staged_q;
    commit         = 1'b0;
    err_d.update   = 1'b0;
    err_d.storage  = err_q.storage | mismatch;

    unique case (state_q)
      IDLE: begin
        if (bus.we_i) begin
          staged_d = bus.wd_i;
          state_d  = STAGED;
        end
      end
      STAGED: begin
        // A write always wins over a simultaneous read.
        if (bus.we_i) begin
          if (bus.wd_i == staged_q) commit = 1'b1;
          else                      err_d.update = 1'b1;
          staged_d = '0;
          state_d  = IDLE;
        end else if (bus.re_i) begin
          staged_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      staged_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      staged_q <= staged_d;
      err_q    <= err_d;
    end
  end

  assign bus.q_o           = committed;
  assign bus.qs_o          = committed;
  assign bus.phase_o       = (state_q == STAGED);
  assign bus.err_update_o  = err_q.update;
  assign bus.err_storage_o = err_q.storage;

endmodule : shadow_reg_ctrl

// File: tb/tb_shadow_reg_ctrl.sv
// Directed bench for shadow_reg_ctrl (DW=5, RESVAL=5'b11000): inputs driven
// on the falling edge, outputs sampled one full cycle later on the next one.
module tb_shadow_reg_ctrl;

  localparam int            DW     = 5;
  localparam logic [DW-1:0] RESVAL = 5'b11000;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  shadow_reg_ctrl_if #(.DW(DW)) bus ();

  shadow_reg_ctrl #(
    .DW     (DW),
    .RESVAL (RESVAL)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of bus inputs, return at the next falling edge.
  task automatic step(input logic we, input logic re, input logic [DW-1:0] wd);
    bus.we_i = we;
    bus.re_i = re;
    bus.wd_i = wd;
    @(negedge clk);
    bus.we_i = 1'b0;
    bus.re_i = 1'b0;
    bus.wd_i = '0;
  endtask

  task automatic do_reset();
    bus.we_i = 1'b0;
    bus.re_i = 1'b0;
    bus.wd_i = '0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_q",       8'(bus.q_o), 8'd24);
    check("rst_qs",      8'(bus.qs_o), 8'd24);
    check("rst_phase",   8'(bus.phase_o), 8'd0);
    check("rst_err_upd", 8'(bus.err_update_o), 8'd0);
    check("rst_err_st",  8'(bus.err_storage_o), 8'd0);
    check("rst_shadow",  8'(dut.u_storage.shadow_q), 8'h07);

    // Good update
    step(1'b1, 1'b0, 5'h0A);
    check("good_phase1", 8'(bus.phase_o), 8'd1);
    check("good_q_hold", 8'(bus.q_o), 8'd24);
    step(1'b1, 1'b0, 5'h0A);
    check("good_q",      8'(bus.q_o), 8'd10);
    check("good_qs",     8'(bus.qs_o), 8'd10);
    check("good_phase0", 8'(bus.phase_o), 8'd0);
    check("good_err",    8'(bus.err_update_o), 8'd0);
    check("good_shadow", 8'(dut.u_storage.shadow_q), 8'h15);

    // Mismatching second write, then recovery and back-to-back third write
    do_reset();
    step(1'b1, 1'b0, 5'h0A);
    step(1'b1, 1'b0, 5'h15);
    check("mm_err_hi",   8'(bus.err_update_o), 8'd1);
    check("mm_q",        8'(bus.q_o), 8'd24);
    check("mm_phase",    8'(bus.phase_o), 8'd0);
    step(1'b0, 1'b0, 5'h00);
    check("mm_err_lo",   8'(bus.err_update_o), 8'd0);
    check("mm_phase_id", 8'(bus.phase_o), 8'd0);
    step(1'b1, 1'b0, 5'h03);
    check("mm_restage",  8'(bus.phase_o), 8'd1);
    step(1'b1, 1'b0, 5'h03);
    check("mm_commit",   8'(bus.q_o), 8'd3);
    check("mm_no_err",   8'(bus.err_update_o), 8'd0);
    step(1'b1, 1'b0, 5'h07);
    check("b2b_w3_ph",   8'(bus.phase_o), 8'd1);
    check("b2b_w3_q",    8'(bus.q_o), 8'd3);

    // Abort by read while staged
    do_reset();
    step(1'b1, 1'b0, 5'h0A);
    step(1'b0, 1'b1, 5'h00);
    check("ab_phase",    8'(bus.phase_o), 8'd0);
    check("ab_err",      8'(bus.err_update_o), 8'd0);
    step(1'b1, 1'b0, 5'h0A);
    check("ab_q",        8'(bus.q_o), 8'd24);
    check("ab_phase1",   8'(bus.phase_o), 8'd1);

    // Simultaneous write and read commits; idle read is harmless
    do_reset();
    step(1'b1, 1'b0, 5'h0A);
    step(1'b1, 1'b1, 5'h0A);
    check("wr_q",        8'(bus.q_o), 8'd10);
    check("wr_phase",    8'(bus.phase_o), 8'd0);
    step(1'b0, 1'b1, 5'h00);
    check("idle_rd_ph",  8'(bus.phase_o), 8'd0);
    check("idle_rd_q",   8'(bus.q_o), 8'd10);

    // Storage fault: shadow of 10 is 5'b10101, flip bit 0
    force dut.u_storage.shadow_q = 5'b10100;
    #1;
    check("st_not_yet",  8'(bus.err_storage_o), 8'd0);
    @(negedge clk);
    check("st_set",      8'(bus.err_storage_o), 8'd1);
    release dut.u_storage.shadow_q;
    step(1'b0, 1'b0, 5'h00);
    check("st_sticky",   8'(bus.err_storage_o), 8'd1);
    step(1'b1, 1'b0, 5'h03);
    step(1'b1, 1'b0, 5'h03);
    check("st_commit_q", 8'(bus.q_o), 8'd3);
    check("st_after_c",  8'(bus.err_storage_o), 8'd1);
    check("st_shadow",   8'(dut.u_storage.shadow_q), 8'h1C);

    // Asynchronous reset while staged
    step(1'b1, 1'b0, 5'h11);
    check("mr_phase1",   8'(bus.phase_o), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_q",        8'(bus.q_o), 8'd24);
    check("mr_phase",    8'(bus.phase_o), 8'd0);
    check("mr_err_st",   8'(bus.err_storage_o), 8'd0);
    check("mr_err_upd",  8'(bus.err_update_o), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 5'h05);
    check("mr_first_ph", 8'(bus.phase_o), 8'd1);
    check("mr_first_q",  8'(bus.q_o), 8'd24);
    step(1'b1, 1'b0, 5'h05);
    check("mr_commit",   8'(bus.q_o), 8'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_shadow_reg_ctrl

// File: doc/shadow_reg_ctrl.md
# shadow_reg_ctrl

Write sequencer and integrity checker for a shadowed configuration register. Software must write the same value twice in succession before it commits. The block keeps the committed value alongside an inverted shadow copy and flags update mismatches and storage corruption. It sits between the register-bus decode and the consuming datapath, and replaces a bare parameterized reset-value register wherever a field needs fault protection.

## Interface
Parameters:
- DW, 5: register width in bits.
- RESVAL, '0 (logic [DW-1:0]): committed value after reset. A packed-struct parameter may be passed; it is consumed as DW bits.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- we_i  in  1  bus write strobe, one cycle per write.
- wd_i  in  DW  write data, valid with we_i.
- re_i  in  1  bus read strobe of this register.
- q_o  out  DW  committed value, to the datapath.
- qs_o  out  DW  readback value (equals q_o).
- phase_o  out  1  1 while a first write is staged.
- err_update_o  out  1  one-cycle pulse on second-write mismatch.
- err_storage_o  out  1  sticky; committed and shadow copies disagree.

## Operation
- State machine (enum in package): IDLE, STAGED. Reset → IDLE.
- IDLE, we_i:
  - staged ← wd_i.
  - go to STAGED.
- STAGED, we_i, wd_i == staged:
  - committed ← wd_i, shadow ← ~wd_i.
  - go to IDLE.
- STAGED, we_i, wd_i != staged:
  - no commit; err_update_o pulses.
  - go to IDLE. The mismatching value is discarded, not re-staged.
- STAGED, re_i without we_i: abort. Go to IDLE; staged value dropped; no error.
- we_i and re_i in the same cycle: the write is processed, the read has no effect on state.
- IDLE, re_i: no state effect.
- Storage check, every cycle: err_storage_o ← err_storage_o | (committed != ~shadow).
  - Set once, held until reset.
  - Commits continue while it is set; the flag stays set.
- Comparisons are full-width, DW bits. There is no partial write.

## Timing
- Reset values:
  - q_o = qs_o = RESVAL.
  - shadow = ~RESVAL; staged = '0.
  - phase_o = 0, err_update_o = 0, err_storage_o = 0.
- Commit latency: q_o shows the new value in the cycle after the second we_i.
- phase_o rises the cycle after the first we_i. It falls the cycle after the second write or the aborting read.
- err_update_o is registered. It is high exactly one cycle, the cycle after the mismatching write.
- err_storage_o asserts the cycle after a corrupting disagreement appears in the storage flops.
- Back-to-back writes on consecutive cycles are legal:
  - Write 1 stages, write 2 commits or errors.
  - A write 3 in the next cycle stages again.
- Reset mid-sequence (asserted while STAGED):
  - Everything returns to reset values immediately, asynchronously.
  - The next write is treated as a first write.

## Structure
- Package shadow_reg_pkg:
  - shadow_phase_e {IDLE, STAGED}.
  - Struct shadow_err_t {logic update; logic storage;} for aggregating errors at the register-file top.
- Sub-module shadow_reg_storage (DW, RESVAL): committed and inverted shadow flops, a single commit enable, and the raw mismatch output.
- The FSM, staged register and error registers live in shadow_reg_ctrl.

## Test plan
DW=5, RESVAL=5'b11000 unless stated.
- Reset:
  - Hold rst_ni low, then release → q_o=24, phase_o=0, both errors 0.
  - The internal shadow copy reads 5'b00111.
- Good update: write 5'h0A, then 5'h0A on the next cycle.
  - phase_o=1 after the first write.
  - q_o=10 one cycle after the second write; err_update_o stays 0.
- Mismatch:
  - Write 5'h0A, then 5'h15 → err_update_o high exactly one cycle, q_o stays 24, phase_o=0.
  - A following pair 5'h03/5'h03 then commits, q_o=3.
- Abort: write 5'h0A, then re_i alone.
  - phase_o=0, no error.
  - Writing 5'h0A once more leaves q_o=24 and phase_o=1.
- Simultaneous write and read: write 5'h0A, then we_i=1 and re_i=1 with 5'h0A → commit, q_o=10.
- Storage fault and mid-sequence reset:
  - Force one shadow bit → err_storage_o=1 the next cycle; stays 1 after the force is released and after a good commit.
  - Assert rst_ni while STAGED → all outputs return to reset values, err_storage_o=0.
